ingress_pkt_buffer: RTL

Per-port ingress stage that sits directly upstream of the shared-SRAM switch core. One instance per input port. It receives the raw packet stream, parses the header beat, and drops malformed packets or packets whose destination queue is full. Accepted packets are stored and forwarded to the core's write side only once complete.

---
 rtl/ingress_pkt_buffer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ingress_pkt_buffer.sv
// Per-port ingress buffer: parses the header beat, drops bad or unplaceable packets,
// stores accepted packets and forwards them to the switch core only once complete.
module ingress_pkt_buffer #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned NUM_PORTS  = 16,
    parameter int unsigned NUM_PRI    = 8,
    parameter int unsigned BUF_DEPTH  = 64,
    parameter int unsigned DESC_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_sop,
    input  logic                           wr_eop,
    input  logic                           wr_vld,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [NUM_PORTS*NUM_PRI-1:0]   q_full,
    output logic                           out_vld,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [3:0]                     out_dest,
    output logic [2:0]                     out_pri,
    output logic [10:0]                    out_len,
    input  logic                           out_ready,
    output logic [15:0]                    drop_cnt,
    output logic                           busy
);
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned DW = $clog2(DESC_DEPTH);
    localparam int unsigned QW = $clog2(NUM_PORTS * NUM_PRI);
    localparam int unsigned CW = AW + 8;

    typedef struct packed {
        logic [AW:0]  start;
        logic [3:0]   dest;
        logic [2:0]   pri;
        logic [10:0]  len;
        logic [6:0]   exp;
    } desc_t;

    typedef enum logic [1:0] {WrIdle, WrRecv, WrDiscard} wr_state_e;
    typedef enum logic {RdIdle, RdSend} rd_state_e;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    desc_t                 desc_mem [DESC_DEPTH];

    wr_state_e   wr_state;
    rd_state_e   rd_state;
    logic [AW:0] wr_ptr, rd_ptr, pkt_start, cur_start;
    logic [6:0]  beat_cnt, pkt_exp, rd_beat, cur_exp;
    logic [3:0]  pkt_dest;
    logic [2:0]  pkt_pri;
    logic [10:0] pkt_len;
    logic [DW-1:0] desc_wr, desc_rd;
    logic [DW:0]   desc_cnt;

    // Header decode and admission checks
    logic [3:0]    hdr_dest;
    logic [2:0]    hdr_pri;
    logic [10:0]   hdr_len;
    logic [6:0]    hdr_exp;
    logic [QW-1:0] q_idx;
    logic [AW:0]   occ;
    logic [CW-1:0] free_beats;
    logic          hdr_bad, desc_full;

    always_comb begin
        hdr_dest   = wr_data[3:0];
        hdr_pri    = wr_data[6:4];
        hdr_len    = wr_data[17:7];
        hdr_exp    = 7'd1 + 7'((12'(hdr_len) + 12'd31) >> 5);
        q_idx      = QW'(hdr_dest) * QW'(NUM_PRI) + QW'(hdr_pri);
        occ        = wr_ptr - rd_ptr;
        free_beats = CW'(BUF_DEPTH) - CW'(occ);
        desc_full  = (desc_cnt == (DW+1)'(DESC_DEPTH));
        hdr_bad    = (hdr_len == 11'd0) || (hdr_len > 11'd1024) || q_full[q_idx] ||
                     (free_beats < CW'(hdr_exp)) || desc_full || wr_eop;
    end

    logic [6:0] cnt_nxt;
    logic       at_exp, mem_we, drop_ev, rewind, push, pop, load;

    always_comb begin
        cnt_nxt = beat_cnt + 7'd1;
        at_exp  = (cnt_nxt == pkt_exp);
        mem_we  = wr_vld && ((wr_state == WrRecv) ||
                             (wr_state == WrIdle && wr_sop && !hdr_bad));
        drop_ev = wr_vld && (((wr_state == WrIdle) && wr_sop && hdr_bad) ||
                             ((wr_state == WrRecv) &&
                              (wr_sop || (wr_eop && !at_exp) || (!wr_eop && at_exp))));
        rewind  = drop_ev && (wr_state == WrRecv);
        push    = wr_vld && (wr_state == WrRecv) && !wr_sop && wr_eop && at_exp;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (push) desc_mem[desc_wr] <= '{start: pkt_start, dest: pkt_dest, pri: pkt_pri,
                                         len: pkt_len, exp: pkt_exp};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state  <= WrIdle;
            wr_ptr    <= '0;
            pkt_start <= '0;
            beat_cnt  <= '0;
            pkt_exp   <= '0;
            pkt_dest  <= '0;
            pkt_pri   <= '0;
            pkt_len   <= '0;
        end else begin
            if (rewind) wr_ptr <= pkt_start;
            else if (mem_we) wr_ptr <= wr_ptr + (AW+1)'(1);
            unique case (wr_state)
                WrIdle: begin
                    if (wr_vld && wr_sop) begin
                        if (hdr_bad) begin
                            if (!wr_eop) wr_state <= WrDiscard;
                        end else begin
                            pkt_start <= wr_ptr;
                            beat_cnt  <= 7'd1;
                            pkt_exp   <= hdr_exp;
                            pkt_dest  <= hdr_dest;
                            pkt_pri   <= hdr_pri;
                            pkt_len   <= hdr_len;
                            wr_state  <= WrRecv;
                        end
                    end
                end
                WrRecv: begin
                    if (wr_vld) begin
                        beat_cnt <= cnt_nxt;
                        if (wr_sop) wr_state <= wr_eop ? WrIdle : WrDiscard;
                        else if (wr_eop) wr_state <= WrIdle;
                        else if (at_exp) wr_state <= WrDiscard;
                    end
                end
                WrDiscard: begin
                    if (wr_vld && wr_eop) wr_state <= WrIdle;
                end
                default: wr_state <= WrIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_ev && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign busy = (wr_state != WrIdle);

    // Read side: a pop may chain straight into the next descriptor with no idle cycle
    desc_t       ld_desc;
    logic [6:0]  nxt_beat;
    logic [AW-1:0] rd_addr;

    always_comb begin
        pop      = (rd_state == RdSend) && out_vld && out_ready && out_eop;
        load     = ((rd_state == RdIdle) && (desc_cnt != '0)) ||
                   (pop && (desc_cnt > (DW+1)'(1)));
        ld_desc  = (rd_state == RdIdle) ? desc_mem[desc_rd] : desc_mem[desc_rd + DW'(1)];
        nxt_beat = rd_beat + 7'd1;
        rd_addr  = cur_start[AW-1:0] + AW'(nxt_beat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_wr  <= '0;
            desc_rd  <= '0;
            desc_cnt <= '0;
        end else begin
            if (push) desc_wr <= desc_wr + DW'(1);
            if (pop) desc_rd <= desc_rd + DW'(1);
            if (push && !pop) desc_cnt <= desc_cnt + (DW+1)'(1);
            else if (pop && !push) desc_cnt <= desc_cnt - (DW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state  <= RdIdle;
            rd_ptr    <= '0;
            rd_beat   <= '0;
            cur_start <= '0;
            cur_exp   <= '0;
            out_vld   <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
            out_pri   <= '0;
            out_len   <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(cur_exp);
            if (load) begin
                rd_state  <= RdSend;
                rd_beat   <= '0;
                cur_start <= ld_desc.start;
                cur_exp   <= ld_desc.exp;
                out_vld   <= 1'b1;
                out_sop   <= 1'b1;
                out_eop   <= 1'b0;
                out_data  <= mem[ld_desc.start[AW-1:0]];
                out_dest  <= ld_desc.dest;
                out_pri   <= ld_desc.pri;
                out_len   <= ld_desc.len;
            end else if (pop) begin
                rd_state <= RdIdle;
                out_vld  <= 1'b0;
                out_sop  <= 1'b0;
                out_eop  <= 1'b0;
            end else if (rd_state == RdSend && out_ready) begin
                rd_beat  <= nxt_beat;
                out_data <= mem[rd_addr];
                out_sop  <= 1'b0;
                out_eop  <= ((nxt_beat + 7'd1) == cur_exp);
            end
        end
    end

endmodule
